// File: rtl/ov_sccb_pkg.sv
// Shared constants, state encoding and ID compare helper for the SCCB target.
// The read path is built only when SCCB_TARGET_READ_EN is defined.
package ov_sccb_pkg;

  localparam int SCCB_BYTE_W    = 8;
  localparam int SCCB_BIT_CNT_W = 4;

  localparam logic [SCCB_BYTE_W-1:0]    SCCB_ID_MASK  = 8'hFE;
  localparam logic [SCCB_BIT_CNT_W-1:0] SCCB_BIT_LAST = 4'd7;
  localparam logic [SCCB_BIT_CNT_W-1:0] SCCB_BIT_DONE = 4'd8;

  typedef logic [3:0] sccb_state_t;

  localparam sccb_state_t S_IDLE      = 4'd0;
  localparam sccb_state_t S_ID        = 4'd1;
  localparam sccb_state_t S_ID_ACK    = 4'd2;
  localparam sccb_state_t S_SUB       = 4'd3;
  localparam sccb_state_t S_SUB_ACK   = 4'd4;
  localparam sccb_state_t S_WDATA     = 4'd5;
  localparam sccb_state_t S_WDATA_ACK = 4'd6;
  localparam sccb_state_t S_RDATA     = 4'd7;
  localparam sccb_state_t S_RDATA_ACK = 4'd8;
  localparam sccb_state_t S_IGNORE    = 4'd9;

  // Bit 0 of the ID byte is the read/write flag and takes no part in the match.
  function automatic logic id_match(input logic [SCCB_BYTE_W-1:0] rx_id,
                                    input logic [SCCB_BYTE_W-1:0] chip_id);
    return ((rx_id ^ chip_id) & SCCB_ID_MASK) == '0;
  endfunction

endpackage

// File: rtl/ov_sccb_target_line_sync.sv
// Synchronizes sio_c/sio_d into the clk domain and derives sio_c edges and
// START/STOP pulses, all one-cycle wide.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sio_c,
  input  logic i_sio_d,
  output logic o_sio_d,
  output logic o_c_rise,
  output logic o_c_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_c_sync;
  logic [SYNC_STAGES-1:0] r_d_sync;
  logic                   r_c_dly;
  logic                   r_d_dly;
  logic                   w_c;
  logic                   w_d;

  // NOTE: synchronizer flops reset to 1 (idle bus) so leaving reset never looks like a START.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_c_sync <= '1;
      r_d_sync <= '1;
      r_c_dly  <= 1'b1;
      r_d_dly  <= 1'b1;
    end else begin
      r_c_sync <= {r_c_sync[SYNC_STAGES-2:0], i_sio_c};
      r_d_sync <= {r_d_sync[SYNC_STAGES-2:0], i_sio_d};
      r_c_dly  <= w_c;
      r_d_dly  <= w_d;
    end
  end

  assign w_c = r_c_sync[SYNC_STAGES-1];
  assign w_d = r_d_sync[SYNC_STAGES-1];

  assign o_sio_d  = w_d;
  assign o_c_rise = w_c & ~r_c_dly;
  assign o_c_fall = ~w_c & r_c_dly;
  // sio_c must be high on both samples so a clock edge is never read as START/STOP.
  assign o_start  = w_c & r_c_dly & r_d_dly & ~w_d;
  assign o_stop   = w_c & r_c_dly & ~r_d_dly & w_d;

endmodule

// File: rtl/ov_sccb_target.sv
// SCCB target: decodes ID/sub-address/data phases into a byte register port.
// Define SCCB_TARGET_READ_EN to acknowledge the read ID and build the read path.
module ov_sccb_target
  import ov_sccb_pkg::*;
#(
  parameter logic [SCCB_BYTE_W-1:0] CHIP_ADDR   = 8'h42,
  parameter int                     SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sio_c_in,
  input  logic                   sio_d_in,
  output logic                   sio_d_oe,
  output logic                   wr_en,
  output logic [SCCB_BYTE_W-1:0] wr_addr,
  output logic [SCCB_BYTE_W-1:0] wr_data,
  output logic [SCCB_BYTE_W-1:0] rd_addr,
  input  logic [SCCB_BYTE_W-1:0] rd_data,
  output logic                   busy,
  output logic                   id_err
);

`ifdef SCCB_TARGET_READ_EN
  localparam bit READ_ACCEPT = 1'b1;
`else
  localparam bit READ_ACCEPT = 1'b0;
  // Read data has no consumer when the read path is not built.
  logic w_unused_rd_data;
  assign w_unused_rd_data = ^rd_data;
`endif

  logic                      w_sio_d;
  logic                      w_c_rise;
  logic                      w_c_fall;
  logic                      w_start;
  logic                      w_stop;
  logic [SCCB_BYTE_W-1:0]    w_byte;
  logic                      w_last_bit;
  logic                      w_id_ok;

  sccb_state_t               r_state;
  logic [SCCB_BIT_CNT_W-1:0] r_bit_cnt;
  logic [SCCB_BYTE_W-1:0]    r_shift;
  logic [SCCB_BYTE_W-1:0]    r_sub_addr;
  logic                      r_sio_d_oe;
  logic                      r_wr_en;
  logic [SCCB_BYTE_W-1:0]    r_wr_addr;
  logic [SCCB_BYTE_W-1:0]    r_wr_data;
  logic                      r_id_err;

  sccb_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk      (clk),
    .reset    (reset),
    .i_sio_c  (sio_c_in),
    .i_sio_d  (sio_d_in),
    .o_sio_d  (w_sio_d),
    .o_c_rise (w_c_rise),
    .o_c_fall (w_c_fall),
    .o_start  (w_start),
    .o_stop   (w_stop)
  );

  assign w_byte     = {r_shift[SCCB_BYTE_W-2:0], w_sio_d};
  assign w_last_bit = (r_bit_cnt == SCCB_BIT_LAST);
  assign w_id_ok    = id_match(w_byte, CHIP_ADDR) && (READ_ACCEPT || !w_byte[0]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_sub_addr <= '0;
      r_sio_d_oe <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_id_err   <= 1'b0;
    end else begin
      // NOTE: strobes default low here; a later assignment in the same cycle wins.
      r_wr_en  <= 1'b0;
      r_id_err <= 1'b0;
      if (w_start) begin
        r_state    <= S_ID;
        r_bit_cnt  <= '0;
        r_sio_d_oe <= 1'b0;
      end else if (w_stop) begin
        r_state    <= S_IDLE;
        r_bit_cnt  <= '0;
        r_sio_d_oe <= 1'b0;
      end else begin
        case (r_state)
          S_ID, S_SUB, S_WDATA: begin
            if (w_c_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
              if (w_last_bit) begin
                if (r_state == S_ID) begin
                  if (w_id_ok) begin
                    r_state <= S_ID_ACK;
                  end else begin
                    r_id_err <= 1'b1;
                    r_state  <= S_IGNORE;
                  end
                end else if (r_state == S_SUB) begin
                  r_sub_addr <= w_byte;
                  r_state    <= S_SUB_ACK;
                end else begin
                  r_wr_en    <= 1'b1;
                  r_wr_addr  <= r_sub_addr;
                  r_wr_data  <= w_byte;
                  r_sub_addr <= r_sub_addr + 1'b1;
                  r_state    <= S_WDATA_ACK;
                end
              end
            end
          end

          // First falling edge drives the ACK, the second releases it and moves on.
          S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
            if (w_c_fall) begin
              if (!r_sio_d_oe) begin
                r_sio_d_oe <= 1'b1;
              end else begin
                r_sio_d_oe <= 1'b0;
                r_bit_cnt  <= '0;
                if (r_state == S_ID_ACK) begin
`ifdef SCCB_TARGET_READ_EN
                  if (r_shift[0]) begin
                    r_sio_d_oe <= ~rd_data[SCCB_BYTE_W-1];
                    r_shift    <= {rd_data[SCCB_BYTE_W-2:0], 1'b0};
                    r_state    <= S_RDATA;
                  end else begin
                    r_state <= S_SUB;
                  end
`else
                  r_state <= S_SUB;
`endif
                end else begin
                  r_state <= S_WDATA;
                end
              end
            end
          end

`ifdef SCCB_TARGET_READ_EN
          S_RDATA: begin
            if (w_c_rise) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (w_c_fall) begin
              if (r_bit_cnt == SCCB_BIT_DONE) begin
                r_sio_d_oe <= 1'b0;
                r_bit_cnt  <= '0;
                r_state    <= S_RDATA_ACK;
              end else begin
                r_sio_d_oe <= ~r_shift[SCCB_BYTE_W-1];
                r_shift    <= {r_shift[SCCB_BYTE_W-2:0], 1'b0};
              end
            end
          end

          // bit_cnt == 1 marks a master ACK seen; the next falling edge reloads.
          S_RDATA_ACK: begin
            if (w_c_rise) begin
              if (w_sio_d) begin
                r_state <= S_IGNORE;
              end else begin
                r_sub_addr <= r_sub_addr + 1'b1;
                r_bit_cnt  <= 4'd1;
              end
            end else if (w_c_fall && r_bit_cnt == 4'd1) begin
              r_sio_d_oe <= ~rd_data[SCCB_BYTE_W-1];
              r_shift    <= {rd_data[SCCB_BYTE_W-2:0], 1'b0};
              r_bit_cnt  <= '0;
              r_state    <= S_RDATA;
            end
          end
`endif

          default: begin
          end
        endcase
      end
    end
  end

  assign sio_d_oe = r_sio_d_oe;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign rd_addr  = r_sub_addr;
  assign busy     = (r_state != S_IDLE);
  assign id_err   = r_id_err;

endmodule

// File: tb/tb_ov_sccb_target.sv
// Directed bench for ov_sccb_target: a bit-level SCCB master plus a
// transaction-level model of expected register writes, ID errors and sub-address.
`timescale 1ns/1ps
module tb_ov_sccb_target;

  localparam int Q = 8;  // clk cycles per quarter SCCB bit

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       m_c = 1'b1;
  logic       m_d = 1'b1;
  logic       sio_d_line;
  logic       sio_d_oe, wr_en, busy, id_err;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [7:0] mem [256];

  wr_t        exp_wr[$];
  wr_t        seen_wr[$];
  wr_t        e;
  logic [7:0] tx[$];
  int         exp_id_err = 0;
  logic [7:0] model_sub = 8'h00;
  bit         quiet = 1'b0;
  logic       prev_wr = 1'b0, prev_id = 1'b0;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  assign sio_d_line = m_d & ~sio_d_oe;
  assign rd_data    = mem[rd_addr];

  ov_sccb_target dut (
    .clk      (clk),
    .reset    (reset),
    .sio_c_in (m_c),
    .sio_d_in (sio_d_line),
    .sio_d_oe (sio_d_oe),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .id_err   (id_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle out of reset, DUT outputs against the model.
  always @(negedge clk) begin
    if (reset) begin
      if (wr_en) begin
        check("wr_width", prev_wr, 1'b0);
        if (exp_wr.size() == 0) begin
          check("wr_expected", wr_en, 1'b0);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
        end
        seen_wr.push_back('{wr_addr, wr_data});
      end
      if (id_err) begin
        check("id_err_width", prev_id, 1'b0);
        if (exp_id_err == 0) check("id_err_expected", id_err, 1'b0);
        else exp_id_err--;
      end
      if (quiet) check("oe_quiet", sio_d_oe, 1'b0);
      if (!busy) begin
        check("idle_oe", sio_d_oe, 1'b0);
        check("idle_rd_addr", rd_addr, model_sub);
      end
      prev_wr = wr_en;
      prev_id = id_err;
    end else begin
      prev_wr = 1'b0;
      prev_id = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic qwait(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start;
    if (!m_c) begin
      qwait(1); m_d = 1'b1;
      qwait(1); m_c = 1'b1;
    end
    qwait(1); m_d = 1'b0;
    qwait(2); m_c = 1'b0;
  endtask

  task automatic bus_stop;
    qwait(1); m_d = 1'b0;
    qwait(1); m_c = 1'b1;
    qwait(2); m_d = 1'b1;
    qwait(2);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    qwait(1); m_d = b;
    qwait(1); m_c = 1'b1;
    qwait(1); s = sio_d_line;
    qwait(1); m_c = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
    bus_bit(nack, s);
  endtask

  // Full write transaction: ID, sub-address, then every byte queued in tx.
  task automatic write_txn(input logic [7:0] sub);
    logic ack;
    bus_start;
    wr_byte(8'h42, ack);
    check("id_ack", ack, 1'b1);
    check("busy_mid", busy, 1'b1);
    wr_byte(sub, ack);
    check("sub_ack", ack, 1'b1);
    model_sub = sub;
    while (tx.size() > 0) begin
      exp_wr.push_back('{model_sub, tx[0]});
      wr_byte(tx.pop_front(), ack);
      check("data_ack", ack, 1'b1);
      model_sub = model_sub + 8'h01;
    end
    bus_stop;
    check("busy_after_stop", busy, 1'b0);
    check("writes_drained", exp_wr.size(), 0);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] rb;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h0A] = 8'h7B;

    repeat (5) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_oe", sio_d_oe, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_id_err", id_err, 1'b0);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_rd_addr", rd_addr, 8'h00);
    reset = 1'b1;
    qwait(2);

    // 3-phase write
    tx = '{8'h80};
    write_txn(8'h12);
    check("w1_count", seen_wr.size(), 1);
    check("w1_pin", {seen_wr[0].addr, seen_wr[0].data}, 16'h1280);
    check("w1_rd_addr", rd_addr, 8'h13);

    // Burst write with sub-address wrap
    tx = '{8'h11, 8'h22, 8'h33};
    write_txn(8'hFE);
    check("w2_count", seen_wr.size(), 4);
    check("w2_pin0", {seen_wr[1].addr, seen_wr[1].data}, 16'hFE11);
    check("w2_pin1", {seen_wr[2].addr, seen_wr[2].data}, 16'hFF22);
    check("w2_pin2", {seen_wr[3].addr, seen_wr[3].data}, 16'h0033);
    check("w2_rd_addr", rd_addr, 8'h01);

    // 2-phase write of sub-address, then read
    write_txn(8'h0A);
`ifdef SCCB_TARGET_READ_EN
    bus_start;
    wr_byte(8'h43, ack);
    check("rd_id_ack", ack, 1'b1);
    check("rd_addr_during", rd_addr, 8'h0A);
    rd_byte(1'b1, rb);
    check("rd_byte_pin", rb, 8'h7B);
    check("rd_byte_model", rb, mem[model_sub]);
    bus_stop;
`else
    exp_id_err++;
    quiet = 1'b1;
    bus_start;
    wr_byte(8'h43, ack);
    check("rd_id_nack", ack, 1'b0);
    bus_stop;
    quiet = 1'b0;
    check("rd_id_err_seen", exp_id_err, 0);
`endif
    check("rd_rd_addr_after", rd_addr, 8'h0A);

    // Wrong ID, then a normal transaction
    exp_id_err++;
    quiet = 1'b1;
    bus_start;
    wr_byte(8'hCC, ack);
    check("bad_id_nack", ack, 1'b0);
    wr_byte(8'h55, ack);
    check("ignored_nack", ack, 1'b0);
    bus_stop;
    quiet = 1'b0;
    check("bad_id_err_seen", exp_id_err, 0);
    tx = '{8'h5A};
    write_txn(8'h20);
    check("w4_pin", {seen_wr[seen_wr.size()-1].addr, seen_wr[seen_wr.size()-1].data}, 16'h205A);

    // Repeated START mid sub-address, then reset mid data byte
    bus_start;
    wr_byte(8'h42, ack);
    check("rs_first_ack", ack, 1'b1);
    for (int i = 0; i < 4; i++) bus_bit(i[0], s);
    bus_start;
    wr_byte(8'h42, ack);
    check("rs_id_ack", ack, 1'b1);
    wr_byte(8'h33, ack);
    check("rs_sub_ack", ack, 1'b1);
    model_sub = 8'h33;
    for (int i = 0; i < 4; i++) bus_bit(i[1], s);
    reset = 1'b0;
    model_sub = 8'h00;
    m_c = 1'b1;
    repeat (3) @(negedge clk);
    m_d = 1'b1;
    repeat (5) @(negedge clk);
    check("rr_busy", busy, 1'b0);
    check("rr_oe", sio_d_oe, 1'b0);
    check("rr_wr_en", wr_en, 1'b0);
    check("rr_rd_addr", rd_addr, 8'h00);
    reset = 1'b1;
    qwait(2);
    check("rr_no_write", seen_wr.size(), 5);
    tx = '{8'hA5};
    write_txn(8'h05);
    check("w5_pin", {seen_wr[5].addr, seen_wr[5].data}, 16'h05A5);

    qwait(2);
    check("final_writes", exp_wr.size(), 0);
    check("final_id_err", exp_id_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
